// File: rtl/execute_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_buffer
// Brief    : EX->MEM circular buffer with register forwarding and redirect pulse
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage_buffer #(
    parameter int DATA_WIDTH     = 64,
    parameter int DEPTH          = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int PC_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_payload,
    input  logic                        in_rd_wen,
    input  logic [REG_ADDR_WIDTH-1:0]   in_rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]   in_rd_data,
    input  logic                        in_br_taken,
    input  logic [PC_WIDTH-1:0]         in_br_target,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_payload,
    input  logic                        flush,
    input  logic [REG_ADDR_WIDTH-1:0]   fwd_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]   fwd_rs2_addr,
    output logic                        fwd_rs1_hit,
    output logic                        fwd_rs2_hit,
    output logic [REG_DATA_WIDTH-1:0]   fwd_rs1_data,
    output logic [REG_DATA_WIDTH-1:0]   fwd_rs2_data,
    output logic                        irreg_pc_valid,
    output logic [PC_WIDTH-1:0]         irreg_pc,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W:0]   SLOT_LIM = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0]     r_payload [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr [DEPTH];
    logic [REG_DATA_WIDTH-1:0] r_rd_data [DEPTH];
    logic [DEPTH-1:0]          r_rd_wen;
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic                      r_irq_valid;
    logic [PC_WIDTH-1:0]       r_irq_pc;

    logic                      w_push;
    logic                      w_pop;
    logic [REG_DATA_WIDTH:0]   w_rs1_res;
    logic [REG_DATA_WIDTH:0]   w_rs2_res;

    assign in_ready       = (r_count != FULL_CNT);
    assign out_valid      = (r_count != '0);
    assign out_payload    = r_payload[r_head];
    assign occupancy      = r_count;
    assign irreg_pc_valid = r_irq_valid;
    assign irreg_pc       = r_irq_pc;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rd_wen    <= '0;
            r_irq_valid <= 1'b0;
            r_irq_pc    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_payload[i] <= '0;
                r_rd_addr[i] <= '0;
                r_rd_data[i] <= '0;
            end
        end else begin
            r_irq_valid <= w_push & in_br_taken;
            if (w_push & in_br_taken) begin
                r_irq_pc <= in_br_target;
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_payload[r_tail] <= in_payload;
                    r_rd_wen[r_tail]  <= in_rd_wen;
                    r_rd_addr[r_tail] <= in_rd_addr;
                    r_rd_data[r_tail] <= in_rd_data;
                    r_tail <= (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins; slot wraps for non-pow2 depth.
    function automatic logic [REG_DATA_WIDTH:0] fwd_lookup(input logic [REG_ADDR_WIDTH-1:0] query);
        logic [REG_DATA_WIDTH:0] res;
        logic [PTR_W:0]          slot;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = {1'b0, r_head} + (PTR_W+1)'(i);
            if (slot >= SLOT_LIM) begin
                slot = slot - SLOT_LIM;
            end
            if ((CNT_W'(i) < r_count) && r_rd_wen[slot[PTR_W-1:0]] &&
                (r_rd_addr[slot[PTR_W-1:0]] == query) && (query != '0)) begin
                res = {1'b1, r_rd_data[slot[PTR_W-1:0]]};
            end
        end
        return res;
    endfunction

    assign w_rs1_res    = fwd_lookup(fwd_rs1_addr);
    assign w_rs2_res    = fwd_lookup(fwd_rs2_addr);
    assign fwd_rs1_hit  = w_rs1_res[REG_DATA_WIDTH];
    assign fwd_rs1_data = w_rs1_res[REG_DATA_WIDTH-1:0];
    assign fwd_rs2_hit  = w_rs2_res[REG_DATA_WIDTH];
    assign fwd_rs2_data = w_rs2_res[REG_DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage_buffer
// Brief    : randomized and directed checks of execute_stage_buffer vs a queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage_buffer;

    localparam int DW    = 64;
    localparam int DEPTH = 3;
    localparam int AW    = 5;
    localparam int RW    = 32;
    localparam int PW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_payload;
    logic          in_rd_wen;
    logic [AW-1:0] in_rd_addr;
    logic [RW-1:0] in_rd_data;
    logic          in_br_taken;
    logic [PW-1:0] in_br_target;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_payload;
    logic          flush;
    logic [AW-1:0] fwd_rs1_addr;
    logic [AW-1:0] fwd_rs2_addr;
    logic          fwd_rs1_hit;
    logic          fwd_rs2_hit;
    logic [RW-1:0] fwd_rs1_data;
    logic [RW-1:0] fwd_rs2_data;
    logic          irreg_pc_valid;
    logic [PW-1:0] irreg_pc;
    logic [CW-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] payload;
        logic          wen;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } entry_t;

    entry_t        m_q[$];
    logic          m_irq_valid;
    logic [PW-1:0] m_irq_pc;

    execute_stage_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_ADDR_WIDTH(AW),
        .REG_DATA_WIDTH(RW), .PC_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_rd_wen(in_rd_wen), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .in_br_taken(in_br_taken), .in_br_target(in_br_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .flush(flush),
        .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
        .irreg_pc_valid(irreg_pc_valid), .irreg_pc(irreg_pc),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_q.delete();
        m_irq_valid = 1'b0;
        m_irq_pc    = '0;
    endfunction

    function automatic void model_update();
        bit     push;
        bit     pop;
        entry_t e;
        push = in_valid && (m_q.size() != DEPTH) && !flush;
        pop  = (m_q.size() != 0) && out_ready && !flush;
        m_irq_valid = push && in_br_taken;
        if (push && in_br_taken) m_irq_pc = in_br_target;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                e.payload = in_payload; e.wen = in_rd_wen;
                e.addr = in_rd_addr; e.data = in_rd_data;
                m_q.push_back(e);
            end
        end
    endfunction

    function automatic void model_fwd(input logic [AW-1:0] q, output logic hit, output logic [RW-1:0] data);
        hit = 1'b0;
        data = '0;
        if (q != 0) begin
            foreach (m_q[i]) begin
                if (m_q[i].wen && m_q[i].addr == q) begin
                    hit = 1'b1;
                    data = m_q[i].data;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_payload = '0; in_rd_wen = 0; in_rd_addr = '0; in_rd_data = '0;
        in_br_taken = 0; in_br_target = '0; out_ready = 0; flush = 0;
        fwd_rs1_addr = '0; fwd_rs2_addr = '0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic push_one(input logic [DW-1:0] p, input logic [AW-1:0] a, input logic [RW-1:0] d);
        in_valid = 1; in_payload = p; in_rd_wen = 1; in_rd_addr = a; in_rd_data = d;
        tick();
        in_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        fwd_rs1_addr = 5'd1; fwd_rs2_addr = 5'd3;
        #1;
        checks++; if (occupancy !== 0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (fwd_rs1_hit !== 1'b0 || fwd_rs2_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got %b%b exp 00", fwd_rs1_hit, fwd_rs2_hit); end
        checks++; if (irreg_pc_valid !== 1'b0 || irreg_pc !== '0) begin errors++; $display("FAIL reset_irreg got %b/%h exp 0/0", irreg_pc_valid, irreg_pc); end
    endtask

    task automatic test_fill_to_full();
        logic [DW-1:0] p[4];
        do_flush();
        for (int k = 0; k < 4; k++) begin
            p[k] = {$urandom, $urandom};
            in_valid = 1; in_payload = p[k]; out_ready = 0;
            #1;
            checks++; if (in_ready !== (k < 3)) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp %b", k, in_ready, (k < 3)); end
            tick();
        end
        in_valid = 0;
        #1;
        checks++; if (occupancy !== 3) begin errors++; $display("FAIL fill_occ got %0d exp 3", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", in_ready); end
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_payload !== p[k]) begin errors++; $display("FAIL fill_pop[%0d] got %b/%h exp 1/%h", k, out_valid, out_payload, p[k]); end
            tick();
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained got %b exp 0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] p[$];
        int            popped;
        logic [DW-1:0] exp_p;
        do_flush();
        popped = 0;
        out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 7);
            in_payload = {$urandom, $urandom};
            if (k < 7) p.push_back(in_payload);
            #1;
            checks++; if (occupancy > 1) begin errors++; $display("FAIL wrap_occ[%0d] got %0d exp <=1", k, occupancy); end
            if (k > 0) begin
                exp_p = p[popped];
                checks++; if (out_valid !== 1'b1 || out_payload !== exp_p) begin errors++; $display("FAIL wrap_order[%0d] got %b/%h exp 1/%h", k, out_valid, out_payload, exp_p); end
                popped++;
            end
            tick();
        end
        in_valid = 0; out_ready = 0;
        #1;
        checks++; if (occupancy !== 0) begin errors++; $display("FAIL wrap_end_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_fwd_priority();
        do_flush();
        push_one(64'h1, 5'd5, 32'hAA);
        push_one(64'h2, 5'd5, 32'hBB);
        fwd_rs1_addr = 5'd5; fwd_rs2_addr = 5'd0;
        #1;
        checks++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'hBB) begin errors++; $display("FAIL fwd_youngest got %b/%h exp 1/bb", fwd_rs1_hit, fwd_rs1_data); end
        checks++; if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 32'h0) begin errors++; $display("FAIL fwd_zero got %b/%h exp 0/0", fwd_rs2_hit, fwd_rs2_data); end
        fwd_rs2_addr = 5'd6;
        #1;
        checks++; if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 32'h0) begin errors++; $display("FAIL fwd_miss got %b/%h exp 0/0", fwd_rs2_hit, fwd_rs2_data); end
        // pop the older entry; the younger still forwards
        out_ready = 1; tick(); out_ready = 0;
        #1;
        checks++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'hBB) begin errors++; $display("FAIL fwd_after_pop got %b/%h exp 1/bb", fwd_rs1_hit, fwd_rs1_data); end
    endtask

    task automatic test_redirect();
        do_flush();
        in_valid = 1; in_br_taken = 1; in_br_target = 32'h0000_1000;
        tick();
        in_valid = 0; in_br_taken = 0; in_br_target = 32'hDEAD_BEEF;
        #1;
        checks++; if (irreg_pc_valid !== 1'b1 || irreg_pc !== 32'h0000_1000) begin errors++; $display("FAIL redirect_pulse got %b/%h exp 1/00001000", irreg_pc_valid, irreg_pc); end
        tick();
        #1;
        checks++; if (irreg_pc_valid !== 1'b0 || irreg_pc !== 32'h0000_1000) begin errors++; $display("FAIL redirect_hold got %b/%h exp 0/00001000", irreg_pc_valid, irreg_pc); end
    endtask

    task automatic test_flush_with_push();
        do_flush();
        push_one(64'h11, 5'd1, 32'h1);
        push_one(64'h22, 5'd2, 32'h2);
        #1;
        checks++; if (occupancy !== 2) begin errors++; $display("FAIL flush_pre_occ got %0d exp 2", occupancy); end
        flush = 1; in_valid = 1; in_br_taken = 1; in_br_target = 32'h0000_2000; out_ready = 1;
        tick();
        flush = 0; in_valid = 0; in_br_taken = 0; out_ready = 0;
        #1;
        checks++; if (occupancy !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_occ got %0d/%b exp 0/0", occupancy, out_valid); end
        checks++; if (irreg_pc_valid !== 1'b0) begin errors++; $display("FAIL flush_no_redirect got %b exp 0", irreg_pc_valid); end
    endtask

    task automatic test_async_reset();
        do_flush();
        push_one(64'h33, 5'd3, 32'h3);
        push_one(64'h44, 5'd4, 32'h4);
        in_valid = 1; in_br_taken = 1; in_br_target = 32'h0000_3000; fwd_rs1_addr = 5'd3;
        #2 rst = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 0) begin errors++; $display("FAIL async_rst_immediate got %b/%0d exp 0/0", out_valid, occupancy); end
        checks++; if (in_ready !== 1'b1 || fwd_rs1_hit !== 1'b0) begin errors++; $display("FAIL async_rst_ready_fwd got %b/%b exp 1/0", in_ready, fwd_rs1_hit); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; in_br_taken = 0;
        rst = 1;
        tick();
        #1;
        checks++; if (irreg_pc_valid !== 1'b0 || irreg_pc !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_after got %b/%h/%b exp 0/0/0", irreg_pc_valid, irreg_pc, out_valid); end
    endtask

    task automatic test_random();
        logic          eh1, eh2;
        logic [RW-1:0] ed1, ed2;
        int            cyc_errs;
        do_flush();
        for (int c = 0; c < 400; c++) begin
            in_valid     = ($urandom % 4) != 0;
            out_ready    = ($urandom % 3) != 0;
            flush        = ($urandom % 25) == 0;
            in_payload   = {$urandom, $urandom};
            in_rd_wen    = ($urandom % 4) != 0;
            in_rd_addr   = AW'($urandom % 4);
            in_rd_data   = $urandom;
            in_br_taken  = ($urandom % 4) == 0;
            in_br_target = $urandom;
            fwd_rs1_addr = AW'($urandom % 4);
            fwd_rs2_addr = AW'($urandom % 4);
            #1;
            model_fwd(fwd_rs1_addr, eh1, ed1);
            model_fwd(fwd_rs2_addr, eh2, ed2);
            cyc_errs = errors;
            checks++; if (occupancy !== CW'(m_q.size())) begin errors++; $display("FAIL rand_occ[%0d] got %0d exp %0d", c, occupancy, m_q.size()); end
            checks++; if (out_valid !== (m_q.size() != 0) || in_ready !== (m_q.size() != DEPTH)) begin errors++; $display("FAIL rand_flags[%0d] got v%b r%b exp size %0d", c, out_valid, in_ready, m_q.size()); end
            if (m_q.size() != 0) begin
                checks++; if (out_payload !== m_q[0].payload) begin errors++; $display("FAIL rand_payload[%0d] got %h exp %h", c, out_payload, m_q[0].payload); end
            end
            checks++; if (fwd_rs1_hit !== eh1 || fwd_rs1_data !== ed1) begin errors++; $display("FAIL rand_fwd1[%0d] got %b/%h exp %b/%h", c, fwd_rs1_hit, fwd_rs1_data, eh1, ed1); end
            checks++; if (fwd_rs2_hit !== eh2 || fwd_rs2_data !== ed2) begin errors++; $display("FAIL rand_fwd2[%0d] got %b/%h exp %b/%h", c, fwd_rs2_hit, fwd_rs2_data, eh2, ed2); end
            checks++; if (irreg_pc_valid !== m_irq_valid || irreg_pc !== m_irq_pc) begin errors++; $display("FAIL rand_irreg[%0d] got %b/%h exp %b/%h", c, irreg_pc_valid, irreg_pc, m_irq_valid, m_irq_pc); end
            if (errors - cyc_errs > 0 && errors > 40) break;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_fill_to_full();
        test_wrap();
        test_fwd_priority();
        test_redirect();
        test_flush_with_push();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage_buffer.md
EXECUTE_STAGE_BUFFER -- requirements
Module: execute_stage_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of the opaque EX->MEM payload in bits.
REQ-002 SHALL have parameter DEPTH, default 2, number of buffer entries, legal range 2..8, not restricted to powers of two.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, width of the destination register index.
REQ-004 SHALL have parameter REG_DATA_WIDTH, default 32, width of the forwarded register value.
REQ-005 SHALL have parameter PC_WIDTH, default 32, width of the redirect PC.
REQ-006 SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  EX result offered.
- in_ready  out  1  buffer can accept.
- in_payload  in  DATA_WIDTH  EX->MEM payload.
- in_rd_wen  in  1  result writes a register.
- in_rd_addr  in  REG_ADDR_WIDTH  destination register.
- in_rd_data  in  REG_DATA_WIDTH  destination value.
- in_br_taken  in  1  control transfer resolved taken.
- in_br_target  in  PC_WIDTH  redirect target.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM stage consumes head.
- out_payload  out  DATA_WIDTH  head payload.
- flush  in  1  discard all contents.
- fwd_rs1_addr, fwd_rs2_addr  in  REG_ADDR_WIDTH  forwarding queries.
- fwd_rs1_hit, fwd_rs2_hit  out  1  query matched.
- fwd_rs1_data, fwd_rs2_data  out  REG_DATA_WIDTH  forwarded value.
- irreg_pc_valid  out  1  one-cycle redirect pulse.
- irreg_pc  out  PC_WIDTH  redirect target.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Function
REQ-007 SHALL be a circular FIFO with head and tail pointers that wrap from DEPTH-1 to 0, plus an occupancy counter.
REQ-008 SHALL define push as in_valid & in_ready & ~flush, and pop as out_valid & out_ready & ~flush.
REQ-009 SHALL drive in_ready = (occupancy != DEPTH), registered-state only, with no combinational path from out_ready.
REQ-010 SHALL leave occupancy unchanged on a simultaneous push and pop while not full, with both pointers advancing.
REQ-011 SHALL drive out_valid = (occupancy != 0) and out_payload from the head slot; out_payload is don't-care when out_valid = 0.
REQ-012 SHALL make a pushed entry visible at the output the cycle after the push, giving latency 1 when empty.
REQ-013 SHALL, on flush = 1, zero occupancy and both pointers at the next edge, ignoring any same-cycle push and pop.
REQ-014 SHALL, for each forwarding port, assert hit when some valid entry has rd_wen = 1 and rd_addr equal to the query.
REQ-015 SHALL return, on a forwarding hit, the data of the youngest matching entry.
REQ-016 SHALL never hit for a query address of 0.
REQ-017 SHALL drive data = 0 whenever the corresponding hit = 0.
REQ-018 SHALL evaluate forwarding combinationally against the registered contents only; the same-cycle in_* entry is not searched.
REQ-019 SHALL, on a push with in_br_taken = 1, assert irreg_pc_valid for exactly the next cycle with irreg_pc = in_br_target.
REQ-020 SHALL otherwise hold irreg_pc_valid = 0, with irreg_pc holding its last value.
REQ-021 SHALL issue no redirect pulse for an input dropped by flush or by a full buffer.
REQ-022 SHALL ensure occupancy never exceeds DEPTH or underflows below 0.

Reset
REQ-023 SHALL, while rst = 0 and asynchronously, force occupancy = 0, pointers = 0, all storage = 0, irreg_pc_valid = 0, and irreg_pc = 0.
REQ-024 SHALL, as a consequence of reset, present out_valid = 0, in_ready = 1, and all fwd hits = 0.
REQ-025 SHALL, when reset is asserted mid-operation, discard all entries with no redirect pulse afterwards.

Verification
REQ-026 SHALL cover fill-to-full: DEPTH = 3, 4 pushes with out_ready = 0 -> in_ready = 0 after the 3rd push, the 4th is not accepted, occupancy = 3, pop order equals push order.
REQ-027 SHALL cover wrap-around: DEPTH = 3, 7 pushes with concurrent pops -> payloads exit in order and occupancy never exceeds 1.
REQ-028 SHALL cover forwarding priority: entries (rd = 5, 0xAA) then (rd = 5, 0xBB) with query rs1 = 5 -> hit = 1, data = 0xBB; query rs2 = 0 -> hit = 0, data = 0.
REQ-029 SHALL cover flush with push: buffer at occupancy 2, flush = 1 while in_valid = 1 and in_br_taken = 1 -> occupancy = 0 next cycle and no irreg_pc_valid pulse.
REQ-030 SHALL cover redirect: push with in_br_taken = 1 and target 0x0000_1000 -> irreg_pc_valid = 1 for one cycle with irreg_pc = 0x0000_1000.
REQ-031 SHALL cover async reset: rst driven low between clock edges at occupancy 2 -> out_valid = 0 immediately, before the next edge.
